// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_entry_t : one prefetch queue entry {pc, instr}
//   INSTR_BYTES   : PC increment per fetched instruction
//   NOP_INSTR     : canonical no-op encoding used to fill unused memory
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of fetch_entry_t used as the prefetch queue.
// Ports:
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   push, wdata : enqueue request and entry (ignored when full unless popping)
//   pop         : dequeue head entry (ignored when empty)
//   flush       : synchronous clear of count and pointers; wins over push/pop
//   rdata       : head entry, straight from registered storage
//   full, empty : occupancy status
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of a combinational instruction ROM.
// Ports:
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   imem_addr       : word-aligned fetch address (the fetch PC)
//   imem_rdata      : instruction word returned in the same cycle
//   redirect_valid  : load redirect_pc (bits [1:0] dropped) and flush the queue
//   redirect_pc     : redirect target
//   inst_valid      : head entry available to decode
//   inst_ready      : decode accepts the head entry
//   inst_out        : head instruction word
//   inst_pc         : PC of the head instruction
//   inst_pc_plus4   : inst_pc + 4, wrapping modulo 2^32
//   misalign_err    : one-cycle pulse after a redirect to a non-word-aligned target
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus4,
    output logic        misalign_err
);

    logic [31:0]  fetch_pc;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    fetch_entry_t new_entry;
    fetch_entry_t head;

    assign imem_addr  = fetch_pc;
    assign inst_valid = !empty;
    assign pop        = inst_valid && inst_ready;
    // Redirect suppresses the push: the word at the old fetch_pc is on the wrong path.
    assign push       = !redirect_valid && (!full || pop);

    assign new_entry.pc    = fetch_pc;
    assign new_entry.instr = imem_rdata;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (new_entry),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign inst_out      = head.instr;
    assign inst_pc       = head.pc;
    assign inst_pc_plus4 = head.pc + INSTR_BYTES;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc     <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else if (push) begin
                fetch_pc <= fetch_pc + INSTR_BYTES;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven bench for fetch_unit plus hand-written
// sequences for asynchronous reset and PC wrap-around.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (RESET_PC = 0)
    logic        reset;
    logic [31:0] imem_addr, imem_rdata, redirect_pc;
    logic        redirect_valid, inst_valid, inst_ready, misalign_err;
    logic [31:0] inst_out, inst_pc, inst_pc_plus4;

    // Wrap-around DUT (RESET_PC = FFFF_FFF8)
    logic        reset2;
    logic [31:0] imem_addr2, imem_rdata2, redirect_pc2;
    logic        redirect_valid2, inst_valid2, inst_ready2, misalign_err2;
    logic [31:0] inst_out2, inst_pc2, inst_pc_plus42;

    logic [31:0] mem [64];
    assign imem_rdata  = mem[imem_addr[7:2]];
    assign imem_rdata2 = mem[imem_addr2[7:2]];

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
        .inst_pc(inst_pc), .inst_pc_plus4(inst_pc_plus4), .misalign_err(misalign_err)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
        .clk(clk), .reset(reset2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .inst_valid(inst_valid2), .inst_ready(inst_ready2), .inst_out(inst_out2),
        .inst_pc(inst_pc2), .inst_pc_plus4(inst_pc_plus42), .misalign_err(misalign_err2)
    );

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] w(input int k);
        return 32'h0010_0093 + 32'(k);
    endfunction

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        v;
        logic        chk;   // compare head pc/instr/plus4 this cycle
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] addr;
        logic        mis;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                                input logic v, input logic chk, input logic [31:0] pc,
                                input logic [31:0] instr, input logic [31:0] addr,
                                input logic mis);
        vec_t r;
        r.rdy = rdy; r.rv = rv; r.rpc = rpc; r.v = v; r.chk = chk;
        r.pc = pc; r.instr = instr; r.addr = addr; r.mis = mis;
        return r;
    endfunction

    vec_t tbl [22];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = (i < 32) ? w(i) : NOP_INSTR;

        // Inputs applied in cycle i, outputs expected during cycle i (before its edge).
        tbl[0]  = mk(1, 0, 0,     0, 1, 32'h00,  32'h0, 32'h00, 0); // reset state
        tbl[1]  = mk(1, 0, 0,     1, 1, 32'h00,  w(0),  32'h04, 0);
        tbl[2]  = mk(1, 0, 0,     1, 1, 32'h04,  w(1),  32'h08, 0);
        tbl[3]  = mk(1, 0, 0,     1, 1, 32'h08,  w(2),  32'h0C, 0);
        tbl[4]  = mk(0, 0, 0,     1, 1, 32'h0C,  w(3),  32'h10, 0); // backpressure
        tbl[5]  = mk(0, 0, 0,     1, 1, 32'h0C,  w(3),  32'h14, 0);
        tbl[6]  = mk(0, 0, 0,     1, 1, 32'h0C,  w(3),  32'h14, 0);
        tbl[7]  = mk(0, 0, 0,     1, 1, 32'h0C,  w(3),  32'h14, 0);
        tbl[8]  = mk(0, 0, 0,     1, 1, 32'h0C,  w(3),  32'h14, 0);
        tbl[9]  = mk(1, 0, 0,     1, 1, 32'h0C,  w(3),  32'h14, 0); // drain, no bubble
        tbl[10] = mk(1, 0, 0,     1, 1, 32'h10,  w(4),  32'h18, 0);
        tbl[11] = mk(0, 0, 0,     1, 1, 32'h14,  w(5),  32'h1C, 0);
        tbl[12] = mk(0, 1, 32'h40, 1, 1, 32'h14, w(5),  32'h1C, 0); // redirect, full queue
        tbl[13] = mk(1, 0, 0,     0, 0, 32'h0,   32'h0, 32'h40, 0);
        tbl[14] = mk(1, 0, 0,     1, 1, 32'h40,  w(16), 32'h44, 0);
        tbl[15] = mk(1, 1, 32'h42, 1, 1, 32'h44, w(17), 32'h48, 0); // misaligned target
        tbl[16] = mk(1, 0, 0,     0, 0, 32'h0,   32'h0, 32'h40, 1);
        tbl[17] = mk(1, 1, 32'h23, 1, 1, 32'h40, w(16), 32'h44, 0); // back-to-back redirects
        tbl[18] = mk(1, 1, 32'h30, 0, 0, 32'h0,  32'h0, 32'h20, 1);
        tbl[19] = mk(1, 0, 0,     0, 0, 32'h0,   32'h0, 32'h30, 0);
        tbl[20] = mk(1, 0, 0,     1, 1, 32'h30,  w(12), 32'h34, 0);
        tbl[21] = mk(1, 0, 0,     1, 1, 32'h34,  w(13), 32'h38, 0);

        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        reset2 = 1'b1; redirect_valid2 = 1'b0; redirect_pc2 = '0; inst_ready2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            inst_ready     = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            check($sformatf("v%0d.valid", i), 32'(inst_valid), 32'(tbl[i].v));
            check($sformatf("v%0d.addr", i), imem_addr, tbl[i].addr);
            check($sformatf("v%0d.misalign", i), 32'(misalign_err), 32'(tbl[i].mis));
            if (tbl[i].chk) begin
                check($sformatf("v%0d.pc", i), inst_pc, tbl[i].pc);
                check($sformatf("v%0d.instr", i), inst_out, tbl[i].instr);
                check($sformatf("v%0d.plus4", i), inst_pc_plus4, tbl[i].pc + 32'd4);
            end
            @(posedge clk);
            #1;
        end

        // Fill the queue, then assert reset between edges.
        redirect_valid = 1'b0; inst_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst.valid", 32'(inst_valid), 32'd0);
        check("arst.addr", imem_addr, 32'h0);
        check("arst.pc", inst_pc, 32'h0);
        check("arst.instr", inst_out, 32'h0);
        check("arst.plus4", inst_pc_plus4, 32'h4);
        @(posedge clk);
        #1 reset = 1'b0; inst_ready = 1'b1;
        check("rel.valid", 32'(inst_valid), 32'd0);
        @(posedge clk);
        #1;
        check("rel1.valid", 32'(inst_valid), 32'd1);
        check("rel1.pc", inst_pc, 32'h0);
        check("rel1.instr", inst_out, w(0));

        // PC wrap-around on the second instance.
        inst_ready2 = 1'b1;
        reset2 = 1'b0;
        check("wrap0.valid", 32'(inst_valid2), 32'd0);
        check("wrap0.addr", imem_addr2, 32'hFFFF_FFF8);
        @(posedge clk);
        #1;
        check("wrap1.pc", inst_pc2, 32'hFFFF_FFF8);
        check("wrap1.instr", inst_out2, NOP_INSTR);
        check("wrap1.plus4", inst_pc_plus42, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        check("wrap2.pc", inst_pc2, 32'hFFFF_FFFC);
        check("wrap2.plus4", inst_pc_plus42, 32'h0000_0000);
        check("wrap2.addr", imem_addr2, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("wrap3.valid", 32'(inst_valid2), 32'd1);
        check("wrap3.pc", inst_pc2, 32'h0000_0000);
        check("wrap3.instr", inst_out2, w(0));
        check("wrap3.plus4", inst_pc_plus42, 32'h0000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the word-aligned fetch address to the combinational instruction ROM.
- Captures the returned instruction word, with its PC, into a small prefetch queue.
- Presents entries to decode over a valid/ready handshake; accepts branch/jump redirects that flush the queue.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, prefetch queue entries; power of two, >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  32  fetch address to instruction memory; always equals fetch_pc.
- imem_rdata  in  32  instruction word returned combinationally, same cycle.
- redirect_valid  in  1  load new PC and flush the queue.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored.
- inst_valid  out  1  head entry available.
- inst_ready  in  1  consumer accepts the head entry.
- inst_out  out  32  head instruction word.
- inst_pc  out  32  PC of the head instruction.
- inst_pc_plus4  out  32  inst_pc + 4, modulo 2^32.
- misalign_err  out  1  one-cycle pulse: last redirect target was not word aligned.

Behaviour:
- Reset values: fetch_pc = RESET_PC, so imem_addr = RESET_PC. Queue count and pointers = 0, all storage = 0, so inst_valid = 0 and inst_out = inst_pc = 0. inst_pc_plus4 = 4, misalign_err = 0.
- Reset is asynchronous: outputs take their reset values immediately, without waiting for a clock edge. This applies mid-operation, including with a full queue.
- pop = inst_valid & inst_ready.
- push, evaluated each cycle when no redirect is active: (count < DEPTH) | pop.
- On push: enqueue {fetch_pc, imem_rdata}, and fetch_pc <= fetch_pc + 4. The increment wraps 32'hFFFF_FFFC -> 0 with no flag.
- No push: fetch_pc holds.
- Push and pop may occur in the same cycle. With a full queue, pop then push keeps count = DEPTH with no bubble.
- inst_valid = (count != 0). inst_* reflect the head entry straight from registered storage, with no combinational path from imem_rdata.
- Latency: an instruction fetched in cycle N is presented in cycle N+1.
- After reset release, PC RESET_PC is valid the cycle after the first edge.
- Stability: while inst_valid & !inst_ready, inst_out, inst_pc and inst_pc_plus4 hold, unless reset or redirect intervenes.
- Redirect has the highest priority (below reset). At the edge where redirect_valid = 1:
  - count, read pointer and write pointer go to 0; no push occurs.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - A pop in the same cycle still completes from the consumer's view, since the head was presented that cycle. All other entries are discarded and never presented.
  - Cycle after the redirect edge: inst_valid = 0 and imem_addr = target.
  - Cycle after that: target instruction valid.
- misalign_err <= redirect_valid & (redirect_pc[1:0] != 0). It is registered and lasts one cycle.
- Back-to-back redirects: the last one wins, and each restarts the penalty.
- No other states exist; the only state is fetch_pc, the queue and misalign_err.

Decomposition:
- fetch_pkg holds:
  - typedef fetch_entry_t, packed struct {logic [31:0] pc; logic [31:0] instr;}.
  - Constant INSTR_BYTES = 4.
  - Constant NOP_INSTR = 32'h0000_0013, used by the bench to fill unused memory.
- Sub-module fetch_queue: a DEPTH-entry fetch_entry_t FIFO with push, pop and synchronous flush, count, full/empty, and async reset.
- fetch_unit contains the PC register, push/redirect control and the misalign flag.

Test Plan:
- Preload memory word k = 32'h0010_0093 + k (NOP_INSTR elsewhere); release reset with inst_ready = 1 -> inst_pc = 0, 4, 8, 12 on consecutive cycles, inst_out = word 0, 1, 2, 3, inst_pc_plus4 = inst_pc + 4.
- Backpressure:
  - Hold inst_ready = 0 for 5 cycles -> count saturates at 2, imem_addr stays 8, inst_pc stays 0.
  - Then inst_ready = 1 -> inst_pc = 0, 4, 8 with no gap or duplicate.
- With the queue full, redirect_valid = 1 and redirect_pc = 0x40 -> next cycle inst_valid = 0 and imem_addr = 0x40; following cycle inst_pc = 0x40 and inst_out = word 16. Entries at PC 4 and 8 never appear.
- redirect_pc = 0x42 -> misalign_err = 1 for exactly one cycle; the target is presented as inst_pc = 0x40.
- RESET_PC = 32'hFFFF_FFF8 -> inst_pc = FFFF_FFF8, FFFF_FFFC, 0000_0000; inst_pc_plus4 at FFFF_FFFC = 0.
- Assert reset between clock edges with a full queue -> inst_valid = 0 and imem_addr = RESET_PC before the next edge; first valid entry arrives the cycle after the first edge following release.
